// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS-subset control path. It holds
// the state encodings, the opcode and funct values the decoder recognises,
// the ALU control codes, the datapath mux encodings and the fault codes.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // State encodings. These are plain constants rather than an enum so the
  // encoding exported on state_o stays fixed and is easy to read in debug
  // tools.
  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMRD    = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWR    = 4'd5;
  localparam state_t S_RTYPE_EX = 4'd6;
  localparam state_t S_ALU_WB   = 4'd7;
  localparam state_t S_BRANCH   = 4'd8;
  localparam state_t S_ADDI_EX  = 4'd9;
  localparam state_t S_ADDI_WB  = 4'd10;
  localparam state_t S_JUMP     = 4'd11;
  localparam state_t S_FAULT    = 4'd12;

  // Primary opcodes, instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function codes, instr[5:0].
  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,  // B register
    SRCB_FOUR   = 2'b01,  // constant 4
    SRCB_IMM    = 2'b10,  // sign-extended immediate
    SRCB_IMM_SH = 2'b11   // sign-extended immediate << 2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,  // ALU result (PC + 4)
    PCSRC_ALUOUT = 2'b01,  // branch target held in ALUOut
    PCSRC_JUMP   = 2'b10   // {PC[31:28], instr[25:0], 2'b00}
  } pc_src_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_code_e;

  // States that wait on the unified-memory ready handshake.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ---------------------------------------------------------------------------
// mc_alu_decoder
// Combinational R-type funct decoder. Maps instr[5:0] to the ALU operation
// and flags whether the funct belongs to the supported subset.
//   funct    in  6  instr[5:0]
//   alu_ctrl out 4  ALU operation (ADD for NOP and for unsupported codes)
//   legal    out 1  funct is NOP, ADD, SUB, AND, OR, XOR or NOR
// ---------------------------------------------------------------------------
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (funct)
      FN_NOP:  alu_ctrl = ALU_ADD;
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_XOR:  alu_ctrl = ALU_XOR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multicycle control FSM for the 32-bit MIPS-subset core. Sequences the
// shared PC/ALU/memory datapath through fetch, decode, execute, memory and
// writeback, waits on the memory ready handshake, traps illegal
// instructions and memory timeouts, and counts retired instructions.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   opcode, funct         instr[31:26] and instr[5:0] from IR
//   zero                  ALU zero flag
//   mem_ready             memory completes the access this cycle
//   pc_en, pc_write_cond  PC load enable and branch-qualified write
//   iord, mem_read, mem_write, ir_write       memory side controls
//   reg_dst, mem_to_reg, reg_write            register file controls
//   alu_src_a, alu_src_b, alu_ctrl, pc_src    datapath mux and ALU controls
//   fault, fault_code     sticky fault flag and cause
//   instr_count           retired-instruction counter (wraps)
//   state_o               current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,  // 1..255
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_o
);

  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       code_q, code_d;

  logic       retire;
  logic       timeout;
  logic       pc_write;
  logic [3:0] fn_alu_ctrl;
  logic       fn_legal;

  mc_alu_decoder u_alu_decoder (
    .funct    (funct),
    .alu_ctrl (fn_alu_ctrl),
    .legal    (fn_legal)
  );

  // A memory state has used up its wait budget when it is in its last
  // allowed cycle and memory is still not ready.
  assign timeout = is_mem_state(state_q) && !mem_ready && (wait_q == WAIT_MAX);

  // Next-state, retire and fault-cause logic.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (timeout) begin
          state_d = S_FAULT;
          code_d  = FAULT_TIMEOUT;
        end else if (mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (!fn_legal) begin
              state_d = S_FAULT;
              code_d  = FAULT_ILLEGAL;
            end else if (funct == FN_NOP) begin
              // NOP has nothing to execute or write back.
              state_d = S_FETCH;
              retire  = 1'b1;
            end else begin
              state_d = S_RTYPE_EX;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDI_EX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d = S_FAULT;
            code_d  = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (timeout) begin
          state_d = S_FAULT;
          code_d  = FAULT_TIMEOUT;
        end else if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWR: begin
        if (timeout) begin
          state_d = S_FAULT;
          code_d  = FAULT_TIMEOUT;
        end else if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_RTYPE_EX: state_d = S_ALU_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEMWB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      // Unused encodings recover by restarting the fetch.
      default: state_d = S_FETCH;
    endcase
  end

  // The wait counter restarts whenever the state changes, so each memory
  // state gets its own full budget.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (is_mem_state(state_q) && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign count_d = count_q + {{(CNT_W-1){1'b0}}, retire};

  // NOTE: the reset here is synchronous, so it lives inside the clocked
  // block and is sampled only on the rising edge like any other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      count_q <= '0;
      code_q  <= FAULT_NONE;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its next value from the same pre-edge snapshot.
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      code_q  <= code_d;
    end
  end

  // Moore outputs on state. The fetch handshake strobes follow mem_ready,
  // and the timeout cycle issues no memory or fetch strobe.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_ctrl      = ALU_ADD;
    pc_src        = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = !timeout;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = !timeout;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = !timeout;
        iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = fn_alu_ctrl;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign pc_en       = pc_write | (pc_write_cond & zero);
  assign fault       = (state_q == S_FAULT);
  assign fault_code  = code_q;
  assign instr_count = count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
// Self-checking bench for mc_controller. Each instruction is expanded by a
// behavioural model into the list of cycles it should take (state, memory
// ready level, timeout cycle, retirement, fault cause); the bench drives
// mem_ready from that list and compares every output every cycle.
// ---------------------------------------------------------------------------
module tb_mc_controller;

  localparam int WL = 4;  // wait limit used for the whole run
  localparam int CW = 4;  // small counter so wrap-around is reached

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_en, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic          reg_dst, mem_to_reg, reg_write, alu_src_a, fault;
  logic [1:0]    alu_src_b, pc_src, fault_code;
  logic [3:0]    alu_ctrl, state_o;
  logic [CW-1:0] instr_count;

  mc_controller #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_en         (pc_en),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_ctrl      (alu_ctrl),
    .pc_src        (pc_src),
    .fault         (fault),
    .fault_code    (fault_code),
    .instr_count   (instr_count),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    bit         ready;
    bit         timeout;
    bit         retire;
    logic [1:0] code;
  } cyc_t;

  cyc_t          plan[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [CW-1:0] cnt_m = '0;

  // ---------------- reference model ----------------
  function automatic logic [3:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h26:   return 4'b0011;
      6'h27:   return 4'b1100;
      default: return 4'b0010;
    endcase
  endfunction

  // Expected control word for one planned cycle:
  // {pc_en, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, fault,
  //  fault_code}
  function automatic logic [20:0] exp_out(input cyc_t c, input logic z,
                                          input logic [5:0] fn);
    logic pw, pwc, io, mr, mw, irw, rd, m2r, rw, sa;
    logic [1:0] sb, ps;
    logic [3:0] ac;
    {pw, pwc, io, mr, mw, irw, rd, m2r, rw, sa} = '0;
    sb = 2'b00;
    ps = 2'b00;
    ac = 4'b0010;
    case (c.st)
      4'd0:  begin mr = !c.timeout; irw = c.ready; pw = c.ready; sb = 2'b01; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  begin mr = !c.timeout; io = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mw = !c.timeout; io = 1'b1; end
      4'd6:  begin sa = 1'b1; ac = fn_alu(fn); end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin sa = 1'b1; ac = 4'b0110; pwc = 1'b1; ps = 2'b01; end
      4'd9:  begin sa = 1'b1; sb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin pw = 1'b1; ps = 2'b10; end
      default: ;
    endcase
    return {pw | (pwc & z), pwc, io, mr, mw, irw, rd, m2r, rw, sa, sb, ac, ps,
            (c.st == 4'd12), c.code};
  endfunction

  task automatic push(input logic [3:0] st, input bit rdy, input bit to,
                      input bit ret, input logic [1:0] code);
    cyc_t c;
    c.st = st; c.ready = rdy; c.timeout = to; c.retire = ret; c.code = code;
    plan.push_back(c);
  endtask

  // A memory phase: `waits` not-ready cycles then the ready cycle, or a
  // timeout once the wait limit is reached.
  task automatic push_mem(input logic [3:0] st, input int waits,
                          input bit ret, output bit flt);
    flt = (waits >= WL);
    if (flt) begin
      for (int k = 0; k < WL; k++) push(st, 1'b0, k == WL-1, 1'b0, 2'd0);
    end else begin
      for (int k = 0; k < waits; k++) push(st, 1'b0, 1'b0, 1'b0, 2'd0);
      push(st, 1'b1, 1'b0, ret, 2'd0);
    end
  endtask

  task automatic push_fault(input logic [1:0] code, input int hold);
    for (int k = 0; k < hold; k++) push(4'd12, 1'b0, 1'b0, 1'b0, code);
  endtask

  // Expand one instruction into its expected cycle list.
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int wf, input int wm, input int hold);
    bit flt;
    plan.delete();
    push_mem(4'd0, wf, 1'b0, flt);
    if (flt) begin push_fault(2'd2, hold); return; end
    push(4'd1, 1'b0, 1'b0, (op == 6'h00) && (fn == 6'h00), 2'd0);
    case (op)
      6'h23: begin
        push(4'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        push_mem(4'd3, wm, 1'b0, flt);
        if (flt) push_fault(2'd2, hold);
        else push(4'd4, 1'b0, 1'b0, 1'b1, 2'd0);
      end
      6'h2B: begin
        push(4'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        push_mem(4'd5, wm, 1'b1, flt);
        if (flt) push_fault(2'd2, hold);
      end
      6'h00: begin
        if (!(fn inside {6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27}))
          push_fault(2'd1, hold);
        else if (fn != 6'h00) begin
          push(4'd6, 1'b0, 1'b0, 1'b0, 2'd0);
          push(4'd7, 1'b0, 1'b0, 1'b1, 2'd0);
        end
      end
      6'h04: push(4'd8, 1'b0, 1'b0, 1'b1, 2'd0);
      6'h08: begin
        push(4'd9, 1'b0, 1'b0, 1'b0, 2'd0);
        push(4'd10, 1'b0, 1'b0, 1'b1, 2'd0);
      end
      6'h02: push(4'd11, 1'b0, 1'b0, 1'b1, 2'd0);
      default: push_fault(2'd1, hold);
    endcase
  endtask

  // ---------------- drivers / checkers ----------------
  // Called just after a rising edge; leaves time just after a rising edge.
  task automatic apply(input string name, input int n_max, input bit reset_last);
    int n;
    logic [28:0] got, exp;
    n = (n_max < plan.size()) ? n_max : plan.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = plan[i].ready;
      if (reset_last && (i == n-1)) reset = 1'b1;
      @(negedge clk);
      exp = {plan[i].st, exp_out(plan[i], zero, funct), cnt_m};
      got = {state_o, pc_en, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
             pc_src, fault, fault_code, instr_count};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got state=%0d ctl=%h cnt=%0d, expected state=%0d ctl=%h cnt=%0d",
                 name, i, got[28:25], got[24:4], got[3:0],
                 exp[28:25], exp[24:4], exp[3:0]);
      end
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        cnt_m = '0;
      end else if (plan[i].retire) begin
        cnt_m = cnt_m + 1'b1;
      end
    end
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt_m = '0;
  endtask

  task automatic run(input string name, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input int wf,
                     input int wm, input int hold);
    set_instr(op, fn, z);
    build(op, fn, wf, wm, hold);
    apply(name, plan.size(), 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    plan.delete();
    push(4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    apply("reset_state", 1, 1'b0);
    do_reset();
  endtask

  task automatic test_addi();
    run("addi", 6'h08, 6'h01, 1'b0, 0, 0, 0);  // 0x20020001
  endtask

  task automatic test_lw();
    run("lw_waits", 6'h23, 6'h04, 1'b0, 2, 2, 0);  // 0x8c020004
  endtask

  task automatic test_beq();
    run("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0, 0);
    run("beq_not_taken", 6'h04, 6'h00, 1'b0, 0, 0, 0);
  endtask

  task automatic test_jump();
    run("jump", 6'h02, 6'h00, 1'b0, 0, 0, 0);  // 0x08000000
    run("after_jump", 6'h00, 6'h20, 1'b0, 1, 0, 0);
  endtask

  task automatic test_limit_cycle_ok();
    run("fetch_ready_at_limit", 6'h08, 6'h00, 1'b0, WL-1, 0, 0);
    run("sw_ready_at_limit", 6'h2B, 6'h00, 1'b0, 0, WL-1, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] rfn[7] = '{6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    logic [5:0] op, fn;
    for (int i = 0; i < 40; i++) begin
      fn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 5))
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin op = 6'h00; fn = rfn[$urandom_range(0, 6)]; end
        3: op = 6'h04;
        4: op = 6'h08;
        default: op = 6'h02;
      endcase
      run("random", op, fn, 1'($urandom_range(0, 1)),
          $urandom_range(0, WL-1), $urandom_range(0, WL-1), 0);
    end
  endtask

  task automatic test_illegal();
    run("illegal_opcode", 6'h3F, 6'h00, 1'b0, 0, 0, 20);
    do_reset();
    run("post_reset_addi", 6'h08, 6'h00, 1'b0, 0, 0, 0);
    run("illegal_funct", 6'h00, 6'h01, 1'b0, 0, 0, 20);
    do_reset();
  endtask

  task automatic test_timeout();
    run("sw_timeout", 6'h2B, 6'h00, 1'b0, 0, WL, 5);
    do_reset();
    run("lw_timeout", 6'h23, 6'h00, 1'b0, 1, WL, 5);
    do_reset();
    run("fetch_timeout", 6'h08, 6'h00, 1'b0, WL, 0, 5);
    do_reset();
  endtask

  task automatic test_reset_mid();
    run("pre_reset_addi", 6'h08, 6'h00, 1'b0, 0, 0, 0);
    set_instr(6'h23, 6'h04, 1'b0);
    build(6'h23, 6'h04, 0, 2, 0);
    apply("reset_in_memrd", 4, 1'b1);  // FETCH, DECODE, MEMADR, MEMRD+reset
    plan.delete();
    push(4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    apply("after_mid_reset", 1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_lw();
    test_beq();
    test_jump();
    test_limit_cycle_ok();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
